load_store_unit: RTL and testbench

- Sits between the MEM pipeline stage and the word-addressed data memory.
- Converts byte/halfword/word load and store requests with byte addresses into word-wide memory accesses.
- Sub-word stores use read-modify-write, since the memory writes whole words only.
- Handles lane extraction and sign extension for loads, misalignment/range checks, and a valid/ready handshake so the pipeline can stall.

---
 rtl/load_store_unit.sv | 188 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests with byte addresses into
// word-wide memory accesses, using read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_W_en,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  localparam logic [29:0] LP_WORDS = 30'(MEM_WORDS);

  state_t      r_state;
  state_t      w_next;
  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [1:0]  r_lane;
  logic [31:0] r_wdata;

  logic        w_accept;
  logic        w_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merge_data;

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_err = 1'b0;
    if (req_size == SZ_RSVD)                           w_err = 1'b1;
    if ((req_size == SZ_HALF) && req_addr[0])          w_err = 1'b1;
    if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) w_err = 1'b1;
    if (req_addr[31:2] >= LP_WORDS)                    w_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_err)                                   w_next = S_RESP;
          else if (req_write && (req_size == SZ_WORD)) w_next = S_WR;
          else                                         w_next = S_RD;
        end
      end
      S_RD:    w_next = S_CAP;
      S_CAP:   w_next = r_write ? S_WR : S_RESP;
      S_WR:    w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Request fields are only sampled on accept; they are don't-care afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_write  <= 1'b0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_lane   <= '0;
      r_wdata  <= '0;
    end else if (w_accept) begin
      r_write  <= req_write;
      r_size   <= req_size;
      r_signed <= req_signed;
      r_lane   <= req_addr[1:0];
      r_wdata  <= req_wdata;
    end
  end

  always_comb begin
    w_byte = mem_read_data[7:0];
    case (r_lane)
      2'd0:    w_byte = mem_read_data[7:0];
      2'd1:    w_byte = mem_read_data[15:8];
      2'd2:    w_byte = mem_read_data[23:16];
      default: w_byte = mem_read_data[31:24];
    endcase
    w_half = r_lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];

    w_load_data = mem_read_data;
    if (r_size == SZ_BYTE) begin
      w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
    end else if (r_size == SZ_HALF) begin
      w_load_data = {{16{r_signed & w_half[15]}}, w_half};
    end
  end

  // Read-modify-write merge: only the addressed lane takes new store data.
  always_comb begin
    w_merge_data = mem_read_data;
    if (r_size == SZ_BYTE) begin
      case (r_lane)
        2'd0:    w_merge_data[7:0]   = r_wdata[7:0];
        2'd1:    w_merge_data[15:8]  = r_wdata[7:0];
        2'd2:    w_merge_data[23:16] = r_wdata[7:0];
        default: w_merge_data[31:24] = r_wdata[7:0];
      endcase
    end else if (r_size == SZ_HALF) begin
      if (r_lane[1]) w_merge_data[31:16] = r_wdata[15:0];
      else           w_merge_data[15:0]  = r_wdata[15:0];
    end else begin
      w_merge_data = r_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_W_en       <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
    end else begin
      mem_W_en   <= (w_next == S_WR);
      resp_valid <= (w_next == S_RESP);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_err) begin
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_address <= {2'b00, req_addr[31:2]};
              if (req_write && (req_size == SZ_WORD)) begin
                mem_write_data <= req_wdata;
              end
            end
          end
        end
        S_CAP: begin
          if (r_write) begin
            mem_write_data <= w_merge_data;
          end else begin
            resp_rdata <= w_load_data;
            resp_err   <= 1'b0;
          end
        end
        S_WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed scoreboard bench for load_store_unit with a word-wide memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_W_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = '0;

  logic        mem_clr = 1'b1;
  logic [31:0] mem [0:127];
  int          wr_cnt = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(128)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_size       (req_size),
    .req_signed     (req_signed),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_W_en       (mem_W_en),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 128; i++) mem[i] <= '0;
    end else if (mem_W_en) begin
      mem[mem_address[6:0]] <= mem_write_data;
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_address;
      wr_data <= mem_write_data;
    end
    mem_read_data <= mem[mem_address[6:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Entered at a falling edge; returns at the falling edge inside the RESP cycle.
  task automatic do_req(input string tag, input logic w, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_d, input logic exp_e, input int lat,
                        input int exp_nwr, input logic [31:0] exp_waddr,
                        input logic [31:0] exp_wdata, input bit hold, input int exp_wait);
    int   waits;
    int   k;
    int   wr0;
    bit   got;
    exp_t e;
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    waits = 0;
    while (!req_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!req_ready) begin
      chk({tag, "/ready_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (exp_wait >= 0) chk({tag, "/accept_gap"}, waits, exp_wait);
    wr0 = wr_cnt;
    e.rdata = exp_d;
    e.err   = exp_e;
    e.lat   = lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) begin
      req_valid  = 1'b0;
      req_write  = 1'($urandom);
      req_size   = 2'($urandom);
      req_signed = 1'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
    end
    got = 0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1;
        break;
      end
      chk({tag, "/busy"}, req_ready, 1'b0);
    end
    if (!got) begin
      chk({tag, "/resp_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    chk({tag, "/latency"}, k, e.lat);
    chk({tag, "/rdata"}, resp_rdata, e.rdata);
    chk({tag, "/err"}, resp_err, e.err);
    chk({tag, "/ready_in_resp"}, req_ready, 1'b0);
    chk({tag, "/writes"}, wr_cnt - wr0, exp_nwr);
    if (exp_nwr > 0) begin
      chk({tag, "/waddr"}, wr_addr, exp_waddr);
      chk({tag, "/wdata"}, wr_data, exp_wdata);
    end
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst/ready",      req_ready, 1'b1);
    chk("rst/resp_valid", resp_valid, 1'b0);
    chk("rst/resp_rdata", resp_rdata, 32'h0);
    chk("rst/resp_err",   resp_err, 1'b0);
    chk("rst/mem_W_en",   mem_W_en, 1'b0);
    chk("rst/mem_addr",   mem_address, 32'h0);
    chk("rst/mem_wdata",  mem_write_data, 32'h0);
    reset   = 1'b0;
    mem_clr = 1'b0;

    do_req("st_w",   1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 32'h0, 0, 2, 1, 32'd4, 32'hDEADBEEF, 0, 0);
    do_req("ld_w",   0, 2'b10, 1, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3, 0, 0, 0, 0, -1);
    do_req("ld_bs",  0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 3, 0, 0, 0, 0, -1);
    do_req("ld_bu",  0, 2'b00, 0, 32'h13, 32'h0, 32'h000000DE, 0, 3, 0, 0, 0, 0, -1);
    do_req("ld_hs",  0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 0, 3, 0, 0, 0, 0, -1);
    do_req("ld_b0",  0, 2'b00, 0, 32'h10, 32'h0, 32'h000000EF, 0, 3, 0, 0, 0, 0, -1);
    do_req("ld_hu",  0, 2'b01, 0, 32'h10, 32'h0, 32'h0000BEEF, 0, 3, 0, 0, 0, 0, -1);
    do_req("st_b",   1, 2'b00, 0, 32'h11, 32'hAAAAAA55, 32'h0, 0, 4, 1, 32'd4, 32'hDEAD55EF, 0, -1);
    do_req("ld_w2",  0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 3, 0, 0, 0, 0, -1);
    do_req("st_h",   1, 2'b01, 0, 32'h16, 32'h1234C3A5, 32'h0, 0, 4, 1, 32'd5, 32'hC3A50000, 0, -1);
    do_req("ld_hs2", 0, 2'b01, 1, 32'h16, 32'h0, 32'hFFFFC3A5, 0, 3, 0, 0, 0, 0, -1);
    do_req("st_top", 1, 2'b00, 0, 32'h1FF, 32'h00000080, 32'h0, 0, 4, 1, 32'd127, 32'h80000000, 0, -1);
    do_req("ld_top", 0, 2'b00, 1, 32'h1FF, 32'h0, 32'hFFFFFF80, 0, 3, 0, 0, 0, 0, -1);

    do_req("e_half", 0, 2'b01, 0, 32'h11, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, -1);
    do_req("e_word", 1, 2'b10, 0, 32'h0E, 32'h12345678, 32'h0, 1, 1, 0, 0, 0, 0, -1);
    do_req("e_rng",  0, 2'b00, 0, 32'h200, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, -1);
    do_req("e_size", 0, 2'b11, 0, 32'h10, 32'h0, 32'h0, 1, 1, 0, 0, 0, 0, -1);
    do_req("ld_ok",  0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 3, 0, 0, 0, 0, -1);

    // Reset landing in the WR cycle of a sub-word store.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'b00;
    req_addr  = 32'h21;
    req_wdata = 32'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_W_en) break;
    end
    chk("rst_wr/wr_cycle", k, 3);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_wr/mem_W_en",   mem_W_en, 1'b0);
    chk("rst_wr/resp_valid", resp_valid, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_wr/no_resp", resp_valid, 1'b0);
      chk("rst_wr/no_write", mem_W_en, 1'b0);
    end
    chk("rst_wr/ready", req_ready, 1'b1);

    do_req("q0", 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEAD55EF, 0, 3, 0, 0, 0, 1, 0);
    do_req("q1", 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFFFFDE, 0, 3, 0, 0, 0, 1, 1);
    do_req("q2", 0, 2'b01, 0, 32'h16, 32'h0, 32'h0000C3A5, 0, 3, 0, 0, 0, 1, 1);
    req_valid = 1'b0;
    @(negedge clk);
    chk("q/idle_ready", req_ready, 1'b1);
    @(negedge clk);
    chk("q/no_extra", resp_valid, 1'b0);
    chk("sb/empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
